// File: rtl/issue_queue_param.sv
// issue_queue_param
//
// Age-ordered issue queue holding up to DEPTH dispatched instructions. Each
// entry has two source operands that are woken from NUM_CDB common-data-bus
// ports. Each cycle the oldest ready entry is offered to one execution unit.
// When it is accepted, the younger entries shift down by one slot, so slot 0
// always holds the oldest instruction.
//
// Handshake semantics (both interfaces): a transfer happens on a rising edge
// where valid && ready are both high. disp_ready is registered-only
// (!queue_full). issue_valid may change while issue_ready is low, because an
// older entry can become ready; the payload is not held stable.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   flush                       synchronous clear; wins over dispatch and issue
//   disp_*                      dispatch request: two operands plus payload
//   cdb_valid/cdb_tag/cdb_data  NUM_CDB broadcast ports, packed with port k at
//                               slice k
//   issue_*                     selected entry, zero when issue_valid is low
//   queue_full, queue_count     occupancy status, registered
module issue_queue_param #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 6,
    parameter int DATA_W  = 32,
    parameter int CMN_W   = 16,
    parameter int NUM_CDB = 2,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      disp_valid,
    output logic                      disp_ready,
    input  logic [TAG_W-1:0]          disp_rs1_tag,
    input  logic [TAG_W-1:0]          disp_rs2_tag,
    input  logic                      disp_rs1_dv,
    input  logic                      disp_rs2_dv,
    input  logic [DATA_W-1:0]         disp_rs1_data,
    input  logic [DATA_W-1:0]         disp_rs2_data,
    input  logic [CMN_W-1:0]          disp_cmn,
    input  logic [NUM_CDB-1:0]        cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
    output logic                      issue_valid,
    input  logic                      issue_ready,
    output logic [DATA_W-1:0]         issue_rs1_data,
    output logic [DATA_W-1:0]         issue_rs2_data,
    output logic [CMN_W-1:0]          issue_cmn,
    output logic                      queue_full,
    output logic [CNT_W-1:0]          queue_count
);

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic              dv;
        logic [DATA_W-1:0] data;
    } operand_t;

    typedef struct packed {
        logic             vld;
        operand_t         rs1;
        operand_t         rs2;
        logic [CMN_W-1:0] cmn;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    entry_t           q     [DEPTH];
    entry_t           q_nxt [DEPTH];
    // One extra always-empty slot so the shift of the top slot needs no
    // special case: it pulls in a cleared entry.
    entry_t           woke  [DEPTH+1];
    entry_t           disp_ent;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] wr_idx;
    logic [CNT_W-1:0] sel;
    logic [DEPTH-1:0] ready;
    logic             any_ready;
    logic             fire;
    logic             accept;

    // Captures data from the lowest-numbered matching port. Operands that
    // already hold data are never overwritten.
    function automatic operand_t wake_op(
        input operand_t                  op,
        input logic [NUM_CDB-1:0]        v,
        input logic [NUM_CDB*TAG_W-1:0]  t,
        input logic [NUM_CDB*DATA_W-1:0] d
    );
        operand_t res;
        logic     hit;
        res = op;
        hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (!op.dv && !hit && v[k] && (t[k*TAG_W +: TAG_W] == op.tag)) begin
                res.dv   = 1'b1;
                res.data = d[k*DATA_W +: DATA_W];
                hit      = 1'b1;
            end
        end
        return res;
    endfunction

    assign queue_full  = (count == CNT_DEPTH);
    assign disp_ready  = !queue_full;
    assign queue_count = count;

    // Readiness comes from registered state only. There is no same-cycle
    // path from the CDB to issue.
    always_comb begin
        ready = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = q[i].vld & q[i].rs1.dv & q[i].rs2.dv;
        end
    end

    always_comb begin
        sel       = '0;
        any_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!any_ready && ready[i]) begin
                sel       = CNT_W'(i);
                any_ready = 1'b1;
            end
        end
    end

    assign issue_valid = any_ready & !flush;
    assign fire        = issue_valid & issue_ready;
    assign accept      = disp_valid & disp_ready & !flush;

    always_comb begin
        issue_rs1_data = '0;
        issue_rs2_data = '0;
        issue_cmn      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (issue_valid && (CNT_W'(i) == sel)) begin
                issue_rs1_data = q[i].rs1.data;
                issue_rs2_data = q[i].rs2.data;
                issue_cmn      = q[i].cmn;
            end
        end
    end

    // Next-state calculation. Wakeup happens first. Compaction then moves the
    // woken contents, so data captured this cycle lands in the destination
    // slot. The new dispatch goes in after compaction, at the first free slot.
    always_comb begin
        woke[DEPTH] = '0;
        for (int j = 0; j < DEPTH; j++) begin
            woke[j] = q[j];
            if (q[j].vld) begin
                woke[j].rs1 = wake_op(q[j].rs1, cdb_valid, cdb_tag, cdb_data);
                woke[j].rs2 = wake_op(q[j].rs2, cdb_valid, cdb_tag, cdb_data);
            end
        end

        disp_ent          = '0;
        disp_ent.vld      = 1'b1;
        disp_ent.rs1.tag  = disp_rs1_tag;
        disp_ent.rs1.dv   = disp_rs1_dv;
        disp_ent.rs1.data = disp_rs1_dv ? disp_rs1_data : '0;
        disp_ent.rs2.tag  = disp_rs2_tag;
        disp_ent.rs2.dv   = disp_rs2_dv;
        disp_ent.rs2.data = disp_rs2_dv ? disp_rs2_data : '0;
        disp_ent.cmn      = disp_cmn;
        disp_ent.rs1      = wake_op(disp_ent.rs1, cdb_valid, cdb_tag, cdb_data);
        disp_ent.rs2      = wake_op(disp_ent.rs2, cdb_valid, cdb_tag, cdb_data);

        wr_idx = fire ? (count - CNT_ONE) : count;

        for (int j = 0; j < DEPTH; j++) begin
            if (fire && (CNT_W'(j) >= sel)) begin
                q_nxt[j] = woke[j+1];
            end else begin
                q_nxt[j] = woke[j];
            end
            if (accept && (CNT_W'(j) == wr_idx)) begin
                q_nxt[j] = disp_ent;
            end
            if (flush) begin
                q_nxt[j] = '0;
            end
        end

        count_nxt = count;
        if (accept) count_nxt = count_nxt + CNT_ONE;
        if (fire)   count_nxt = count_nxt - CNT_ONE;
        if (flush)  count_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                q[j] <= '0;
            end
        end else begin
            count <= count_nxt;
            for (int j = 0; j < DEPTH; j++) begin
                q[j] <= q_nxt[j];
            end
        end
    end

endmodule
